// File: rtl/glitcher_pkg.sv
// Shared constants for the multi-channel glitcher command handler:
// command bytes, field ids, response codes, field widths and FSM encoding.
package glitcher_pkg;

    localparam logic [7:0] CMD_DELAY   = 8'h64;  // 'd'
    localparam logic [7:0] CMD_WIDTH   = 8'h77;  // 'w'
    localparam logic [7:0] CMD_NUM     = 8'h6E;  // 'n'
    localparam logic [7:0] CMD_SPACING = 8'h73;  // 's'
    localparam logic [7:0] CMD_RESET   = 8'h72;  // 'r'
    localparam logic [7:0] CMD_GET     = 8'h67;  // 'g'
    localparam logic [7:0] CMD_TRIG    = 8'h74;  // 't'
    localparam logic [7:0] CMD_HELLO   = 8'h68;  // 'h'

    localparam logic [7:0] FLD_DELAY   = 8'd0;
    localparam logic [7:0] FLD_WIDTH   = 8'd1;
    localparam logic [7:0] FLD_NUM     = 8'd2;
    localparam logic [7:0] FLD_SPACING = 8'd3;
    localparam logic [7:0] FLD_RESET   = 8'd4;

    localparam logic [7:0] ACK = 8'h4B;
    localparam logic [7:0] NAK = 8'h21;

    localparam int DELAY_W   = 16;
    localparam int WIDTH_W   = 8;
    localparam int NUM_W     = 8;
    localparam int SPACING_W = 16;
    localparam int RESET_W   = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_CH, S_GET_PAYLOAD, S_COMMIT,
        S_GET_FIELD, S_GET_MASK, S_TRIGGER, S_RESP
    } state_t;

    function automatic logic is_write(input logic [7:0] c);
        return (c == CMD_DELAY) || (c == CMD_WIDTH) || (c == CMD_NUM) ||
               (c == CMD_SPACING) || (c == CMD_RESET);
    endfunction

    // Number of payload bytes following the channel byte of a write.
    function automatic logic [1:0] payload_len(input logic [7:0] c);
        return ((c == CMD_WIDTH) || (c == CMD_NUM)) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/uart_resp_buffer.sv
// Holds up to six response bytes (byte 0 in data[7:0]) and feeds them to uart_tx.
module uart_resp_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [47:0] data,
    input  logic [2:0]  count,
    input  logic        tx_busy,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        busy
);
    logic [47:0] bytes_q;
    logic [2:0]  cnt;
    logic [2:0]  idx;

    assign busy = (idx != cnt);

    // Issue one byte when the transmitter is free; the tx_en gap covers tx busy's one-cycle lag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bytes_q <= '0;
            cnt     <= '0;
            idx     <= '0;
            tx_en   <= 1'b0;
            tx_data <= '0;
        end else begin
            tx_en <= 1'b0;
            if (load) begin
                bytes_q <= data;
                cnt     <= count;
                idx     <= '0;
            end else if (busy && !tx_busy && !tx_en) begin
                tx_en   <= 1'b1;
                tx_data <= bytes_q[7:0];
                bytes_q <= bytes_q >> 8;
                idx     <= idx + 3'd1;
            end
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver; one-cycle valid pulse at the middle of the stop bit.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       valid,
    output logic [7:0] data
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB + 1);

    logic [1:0]    sync;
    logic          active;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;

    // Synchronise the line, then sample start, 8 data bits (LSB first) and stop mid-bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            active  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            valid   <= 1'b0;
            data    <= '0;
        end else begin
            sync  <= {sync[0], rx};
            valid <= 1'b0;
            if (!active) begin
                if (!sync[1]) begin
                    active  <= 1'b1;
                    cnt     <= CW'(CPB / 2);
                    bit_idx <= '0;
                end
            end else if (cnt != CW'(CPB - 1)) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt     <= '0;
                bit_idx <= bit_idx + 4'd1;
                if (bit_idx == 4'd0) begin
                    if (sync[1]) active <= 1'b0;  // glitch, not a real start bit
                end else if (bit_idx < 4'd9) begin
                    data <= {sync[1], data[7:1]};
                end else begin
                    active <= 1'b0;
                    valid  <= sync[1];
                end
            end
        end
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; accepts a byte on tx_en while not busy.
module uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB + 1);

    logic [9:0]    shreg;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;

    assign tx = shreg[0];

    // Shift out start, data and stop bits; the line idles high from the all-ones register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= '1;
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
        end else if (!busy) begin
            if (tx_en) begin
                shreg   <= {1'b1, tx_data, 1'b0};
                busy    <= 1'b1;
                cnt     <= '0;
                bit_idx <= '0;
            end
        end else if (cnt != CW'(CPB - 1)) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt     <= '0;
            shreg   <= {1'b1, shreg[9:1]};
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'd9) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_cmd_handler_mc.sv
// Host command parser: channel-addressed config writes, readback, masked trigger, responses.
module uart_cmd_handler_mc
    import glitcher_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int NUM_CH         = 2,
    parameter int TIMEOUT_CYCLES = 500_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx_i,
    output logic                  uart_tx_o,
    input  logic [NUM_CH-1:0]     busy_i,
    output logic [16*NUM_CH-1:0]  delay_o,
    output logic [8*NUM_CH-1:0]   width_o,
    output logic [8*NUM_CH-1:0]   num_pulses_o,
    output logic [16*NUM_CH-1:0]  pulse_spacing_o,
    output logic [16*NUM_CH-1:0]  reset_length_o,
    output logic [NUM_CH-1:0]     pulse_en_o,
    output logic [NUM_CH-1:0]     reset_en_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state;
    logic [7:0]      cmd, ch, mask;
    logic [15:0]     stage;
    logic [1:0]      byte_cnt;
    logic [TW-1:0]   to_cnt;
    logic            in_get;

    logic [DELAY_W-1:0]   delay_r   [NUM_CH];
    logic [WIDTH_W-1:0]   width_r   [NUM_CH];
    logic [NUM_W-1:0]     num_r     [NUM_CH];
    logic [SPACING_W-1:0] spacing_r [NUM_CH];
    logic [RESET_W-1:0]   reset_r   [NUM_CH];

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_en, tx_busy;
    logic [7:0]  tx_data;
    logic        resp_load, resp_busy;
    logic [47:0] resp_bytes;
    logic [2:0]  resp_cnt;
    logic [15:0] rd_val;
    logic        rd_ok, rd_wide, trig_ok;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .clk(clk), .rst_n(rst_n), .rx(uart_rx_i), .valid(rx_valid), .data(rx_data)
    );

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_data(tx_data), .tx(uart_tx_o), .busy(tx_busy)
    );

    uart_resp_buffer u_resp (
        .clk(clk), .rst_n(rst_n), .load(resp_load), .data(resp_bytes), .count(resp_cnt),
        .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data), .busy(resp_busy)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign delay_o[16*g +: 16]         = delay_r[g];
        assign width_o[8*g +: 8]           = width_r[g];
        assign num_pulses_o[8*g +: 8]      = num_r[g];
        assign pulse_spacing_o[16*g +: 16] = spacing_r[g];
        assign reset_length_o[16*g +: 16]  = reset_r[g];
    end

    assign in_get  = (state == S_GET_CH) || (state == S_GET_PAYLOAD) ||
                     (state == S_GET_FIELD) || (state == S_GET_MASK);
    assign trig_ok = (mask != 8'h00) && ((mask >> NUM_CH) == 8'h00) &&
                     ((mask[NUM_CH-1:0] & busy_i) == '0);
    assign rd_wide = (rx_data == FLD_DELAY) || (rx_data == FLD_SPACING) || (rx_data == FLD_RESET);

    // Readback mux: selected channel (ch) and field (the byte currently on rx_data).
    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == 8'(i)) begin
                rd_ok = 1'b1;
                case (rx_data)
                    FLD_DELAY:   rd_val = delay_r[i];
                    FLD_WIDTH:   rd_val = {8'h00, width_r[i]};
                    FLD_NUM:     rd_val = {8'h00, num_r[i]};
                    FLD_SPACING: rd_val = spacing_r[i];
                    FLD_RESET:   rd_val = reset_r[i];
                    default:     rd_ok  = 1'b0;
                endcase
            end
        end
    end

    // Command FSM: parse bytes, commit config, fire strobes, load responses, enforce timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cmd        <= '0;
            ch         <= '0;
            mask       <= '0;
            stage      <= '0;
            byte_cnt   <= '0;
            to_cnt     <= '0;
            resp_load  <= 1'b0;
            resp_bytes <= '0;
            resp_cnt   <= '0;
            pulse_en_o <= '0;
            reset_en_o <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                delay_r[i] <= '0; width_r[i] <= '0; num_r[i] <= '0;
                spacing_r[i] <= '0; reset_r[i] <= '0;
            end
        end else begin
            resp_load  <= 1'b0;
            pulse_en_o <= '0;
            reset_en_o <= '0;
            to_cnt     <= (in_get && !rx_valid) ? to_cnt + 1'b1 : '0;
            case (state)
                S_IDLE: if (rx_valid) begin
                    cmd <= rx_data;
                    if (is_write(rx_data) || rx_data == CMD_GET) begin
                        state <= S_GET_CH;
                    end else if (rx_data == CMD_TRIG) begin
                        state <= S_GET_MASK;
                    end else begin
                        resp_load  <= 1'b1;
                        state      <= S_RESP;
                        if (rx_data == CMD_HELLO) begin
                            resp_bytes <= {8'h0A, 8'h6F, 8'h6C, 8'h6C, 8'h65, 8'h48};
                            resp_cnt   <= 3'd6;
                        end else begin
                            resp_bytes <= {40'h0, rx_data};
                            resp_cnt   <= 3'd1;
                        end
                    end
                end
                S_GET_CH: if (rx_valid) begin
                    ch       <= rx_data;
                    byte_cnt <= '0;
                    state    <= (cmd == CMD_GET) ? S_GET_FIELD : S_GET_PAYLOAD;
                end
                S_GET_PAYLOAD: if (rx_valid) begin
                    stage    <= {stage[7:0], rx_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == payload_len(cmd) - 2'd1) state <= S_COMMIT;
                end
                S_COMMIT: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch == 8'(i)) begin
                            case (cmd)
                                CMD_DELAY:   delay_r[i]   <= stage;
                                CMD_WIDTH:   width_r[i]   <= stage[7:0];
                                CMD_NUM:     num_r[i]     <= stage[7:0];
                                CMD_SPACING: spacing_r[i] <= stage;
                                CMD_RESET:   reset_r[i]   <= stage;
                                default: ;
                            endcase
                        end
                    end
                    resp_bytes <= {40'h0, (ch < 8'(NUM_CH)) ? ACK : NAK};
                    resp_cnt   <= 3'd1;
                    resp_load  <= 1'b1;
                    state      <= S_RESP;
                end
                S_GET_FIELD: if (rx_valid) begin
                    resp_load <= 1'b1;
                    state     <= S_RESP;
                    if (!rd_ok) begin
                        resp_bytes <= {40'h0, NAK};
                        resp_cnt   <= 3'd1;
                    end else if (rd_wide) begin
                        resp_bytes <= {24'h0, rd_val[7:0], rd_val[15:8], ACK};
                        resp_cnt   <= 3'd3;
                    end else begin
                        resp_bytes <= {32'h0, rd_val[7:0], ACK};
                        resp_cnt   <= 3'd2;
                    end
                end
                S_GET_MASK: if (rx_valid) begin
                    mask  <= rx_data;
                    state <= S_TRIGGER;
                end
                S_TRIGGER: begin
                    if (trig_ok) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (mask[i]) begin
                                if (reset_r[i] != '0) reset_en_o[i] <= 1'b1;
                                else                  pulse_en_o[i] <= 1'b1;
                            end
                        end
                    end
                    resp_bytes <= {40'h0, trig_ok ? ACK : NAK};
                    resp_cnt   <= 3'd1;
                    resp_load  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: if (!resp_load && !resp_busy) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            // A stalled partial command is dropped silently.
            if (in_get && !rx_valid && to_cnt == TW'(TIMEOUT_CYCLES - 1)) state <= S_IDLE;
        end
    end
endmodule

// File: doc/uart_cmd_handler_mc.md
Name: uart_cmd_handler_mc

Overview:
Multi-channel successor to the single-channel UART command handler for the glitcher. Owns the uart_rx/uart_tx instances and parses host byte commands into per-channel glitch configuration registers for NUM_CH pulse generators. New over the single-channel block:
- channel-addressed writes, staged and committed atomically on the last payload byte;
- field readback;
- ACK/NAK response bytes;
- masked multi-channel trigger, refused while a target channel is busy;
- inter-byte timeout that aborts a partial command.

Parameters:
CLK_FREQ, 50_000_000, system clock in Hz; passed to uart_rx/uart_tx.
BAUD_RATE, 115200, UART baud; passed to uart_rx/uart_tx.
NUM_CH, 2, number of glitch channels; legal range 1..8.
TIMEOUT_CYCLES, 500_000, idle clocks allowed between bytes of one command.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
uart_rx_i  in  1  serial input
uart_tx_o  out  1  serial output
busy_i  in  NUM_CH  per-channel pulse generator busy
delay_o  out  16*NUM_CH  channel i at [16i+15:16i]
width_o  out  8*NUM_CH  pulse width per channel
num_pulses_o  out  8*NUM_CH  pulse count per channel
pulse_spacing_o  out  16*NUM_CH  spacing per channel
reset_length_o  out  16*NUM_CH  target-reset length per channel
pulse_en_o  out  NUM_CH  one-cycle pulse-start strobe
reset_en_o  out  NUM_CH  one-cycle reset-then-pulse strobe

Behaviour:
- Single clock domain, clk. Reset is synchronous, active-low on rst_n.
- Reset values:
  - all configuration outputs 0;
  - strobes 0;
  - state IDLE;
  - response buffer empty;
  - timeout counter 0.
- Multi-byte values are big-endian.
- Write commands have the form cmd, ch, payload. Payload length is 2 for 'd', 's', 'r' and 1 for 'w', 'n'.
  - Payload bytes go to a 16-bit staging register.
  - The selected field of channel ch updates on the clock edge after the last payload byte is sampled.
  - Response is 'K' (0x4B).
  - If ch >= NUM_CH, the payload is still consumed, nothing is written, and the response is '!' (0x21).
- Read command: 'g', ch, field.
  - Field ids: 0 delay, 1 width, 2 num_pulses, 3 spacing, 4 reset_length.
  - Valid request: response is 'K' followed by the value (2 bytes, or 1 byte for width/num_pulses).
  - ch >= NUM_CH or field > 4: response is '!' only.
- Trigger command: 't', mask (8 bits).
  - NAK '!' with no strobes if any of: mask == 0; a mask bit set at index >= NUM_CH; (mask & busy_i) != 0. busy_i is sampled in the TRIGGER state.
  - Otherwise, for each set bit i: reset_en_o[i] = 1 if reset_length of channel i != 0, else pulse_en_o[i] = 1.
  - All selected strobes are high in the same single cycle, which begins at the second rising edge after the mask byte's rx-valid cycle. Response is 'K'.
- 'h': sends "Hello\n" (48 65 6C 6C 6F 0A).
- Any other command byte is echoed back unchanged.
- State machine:
  - IDLE → GET_CH (write or 'g') / GET_MASK / RESP.
  - GET_CH → GET_PAYLOAD (write) or GET_FIELD ('g').
  - GET_PAYLOAD (byte counter) → COMMIT → RESP.
  - GET_FIELD → RESP.
  - GET_MASK → TRIGGER → RESP.
  - RESP → IDLE once the buffer has drained.
- Response buffer:
  - up to 6 bytes plus a count;
  - loaded in a single cycle;
  - a byte is issued when tx busy is low and tx_en was not asserted in the previous cycle;
  - tx_en is a one-cycle pulse.
- rx bytes arriving in COMMIT, TRIGGER or RESP are discarded.
- Timeout:
  - the counter runs only in GET_CH, GET_PAYLOAD, GET_FIELD and GET_MASK, and clears on every rx byte;
  - on reaching TIMEOUT_CYCLES-1 the block returns to IDLE, discards staged data, writes nothing and sends no response.
- Deasserting rst_n mid-command or mid-response:
  - the block returns to IDLE next cycle and all configuration is cleared;
  - uart_tx is reset as well.

Decomposition:
- Package glitcher_pkg holds:
  - command byte constants ('d', 'w', 'n', 's', 'r', 'g', 't', 'h');
  - field id constants;
  - ACK = 0x4B and NAK = 0x21;
  - field widths;
  - state encoding.
- One sub-module, uart_resp_buffer.
  - Inputs: a byte array, a count and a load strobe.
  - Output: bytes serialised into uart_tx.
  - Flag: busy, asserted until the last byte has been accepted.

Test Plan:
- Reset, then "d 01 12 34": delay_o[31:16] = 0x1234 one cycle after the last byte; 'K' transmitted; channel 0 unchanged.
- "w 05 7F" with NUM_CH=2: '!' transmitted; width_o unchanged; block returns to IDLE and accepts a next 'h' → "Hello\n".
- "r 00 00 10", "t 03", busy_i=0: reset_en_o = 01 and pulse_en_o = 10 in the same single cycle; 'K'.
- "t 01" with busy_i[0] = 1: no strobes; '!'. "t 04" with NUM_CH=2: '!'.
- "s 01 AB", then stall TIMEOUT_CYCLES: spacing unchanged; no response; a following "g 01 03" returns 'K' 00 00.
- Set "n 00 09", then "g 00 02" → 'K' 09. Pull rst_n low during the 'K' transmission: all outputs 0 and uart_tx_o idle-high after reset.
